fir_serial_wr_packer: RTL and testbench
=======================================

Name: fir_serial_wr_packer

Overview:
- Write-side front end of the sample FIFO in the iWCLK domain.
- Deserialises a framed, MSB-first serial sample stream into DATAWIDTH-bit words.
- Buffers completed words in a 2-entry skid buffer and drives the FIFO write port (data, increment, full).
- Provides sticky overflow and framing-error flags and a count of words accepted by the FIFO.

Parameters:
- DATAWIDTH, 8, sample word width in bits; must be ≥ 2; equals the FIFO data width.
- CNTW, 16, width of the accepted-word counter.

Ports:
- iWCLK  input  1  write-domain clock.
- iWRST  input  1  reset, asynchronous, active-high.
- iSDAT  input  1  serial data bit.
- iSVLD  input  1  iSDAT/iSFRM valid this cycle.
- iSFRM  input  1  qualified by iSVLD; marks the first (MSB) bit of a word.
- iCLR   input  1  synchronous clear of oOVF/oFERR.
- iFULL  input  1  FIFO full flag.
- oWDAT  output DATAWIDTH  word to FIFO.
- oWINC  output 1  write request to FIFO.
- oOVF   output 1  sticky: a completed word was dropped.
- oFERR  output 1  sticky: a partial word was aborted by a new iSFRM.
- oBUSY  output 1  high while collecting a word or buffer non-empty.
- oWCNT  output CNTW  number of words accepted by the FIFO (modulo 2^CNTW).

Behaviour:
- Reset (async, iWRST=1): state IDLE, bit counter 0, shift register 0, buffer empty. oWDAT=0, oWINC=0, oOVF=0, oFERR=0, oBUSY=0, oWCNT=0.
- A serial bit is taken at a rising iWCLK edge only if iSVLD=1. Cycles with iSVLD=0 change nothing in the shifter.
- FSM, state IDLE:
  - Bits with iSFRM=0 are ignored.
  - A bit with iSFRM=1 loads shift[0]=iSDAT, sets count=1 and moves to SHIFT.
- FSM, state SHIFT:
  - Each valid bit does shift={shift[DATAWIDTH-2:0],iSDAT} and count+1.
  - When count reaches DATAWIDTH the word is complete: push it to the buffer and return to IDLE.
  - A valid bit with iSFRM=1 in SHIFT discards the partial word and sets oFERR. The bit is taken as the MSB of a new word (count=1, stay in SHIFT).
- Skid buffer, 2 entries, FIFO order:
  - oWINC = buffer non-empty; oWDAT = head entry (0 when empty).
  - Pop occurs at an edge where oWINC=1 and iFULL=0; oWCNT increments at the same edge and wraps at 2^CNTW.
  - Push and pop in the same cycle are both performed; occupancy is unchanged.
  - Push with 2 entries and no pop in that cycle: the new word is dropped, oOVF is set, and buffer contents are unchanged.
- Latency: last bit sampled at edge N → oWINC=1, oWDAT valid after edge N → FIFO write at edge N+1 if iFULL=0.
- iFULL=1 holds oWINC and oWDAT stable; no pop occurs.
- iCLR=1 clears oOVF and oFERR at the next edge. If a set condition occurs in the same cycle, set wins.
- oBUSY = (state==SHIFT) | buffer non-empty. Registered-state decode, no latency beyond the state.
- Reset mid-word or with buffer occupied: all contents are lost and outputs return to their reset values immediately.

Test Plan:
- DATAWIDTH=8, stream 0xA5 MSB-first with iSFRM on bit 0, iSVLD=1 continuous, iFULL=0 → oWINC pulses 1 cycle after the 8th bit with oWDAT=0xA5; oWCNT=1.
- Send 0x3C with iSVLD toggling 1/0 each cycle → same single write of 0x3C. Bits before the first iSFRM are ignored.
- Hold iFULL=1 and send 0x11, 0x22, 0x33 → buffer holds 0x11, 0x22; oOVF=1. Release iFULL → writes 0x11 then 0x22 on consecutive edges; oWCNT=2.
- Send 5 bits of a word, then iSFRM with a new word 0xF0 → oFERR=1; only 0xF0 is written.
- Back-to-back words 0x01, 0x02 with iFULL=0 → two writes, each 1 cycle after its last bit. Pulse iCLR → oOVF=oFERR=0.
- Assert iWRST mid-word with buffer occupied → all outputs 0 asynchronously. After release, the next framed word 0x7E is written correctly.

Source files
------------

// File: rtl/fir_serial_wr_packer.sv
// fir_serial_wr_packer: framed MSB-first serial-to-word packer with 2-entry skid buffer feeding the sample FIFO write port
//   iWCLK/iWRST        write-domain clock, async active-high reset
//   iSDAT/iSVLD/iSFRM  serial bit, bit valid, frame start (first/MSB bit)
//   iCLR               sync clear of sticky oOVF/oFERR (set wins)
//   iFULL              FIFO full
//   oWDAT/oWINC        FIFO write data / write request
//   oOVF/oFERR         sticky: word dropped / partial word aborted
//   oBUSY              collecting a word or buffer non-empty
//   oWCNT              words accepted by the FIFO, wrapping
module fir_serial_wr_packer #(
    parameter int DATAWIDTH = 8,
    parameter int CNTW      = 16
) (
    input  logic                 iWCLK,
    input  logic                 iWRST,
    input  logic                 iSDAT,
    input  logic                 iSVLD,
    input  logic                 iSFRM,
    input  logic                 iCLR,
    input  logic                 iFULL,
    output logic [DATAWIDTH-1:0] oWDAT,
    output logic                 oWINC,
    output logic                 oOVF,
    output logic                 oFERR,
    output logic                 oBUSY,
    output logic [CNTW-1:0]      oWCNT
);
    localparam int CW = $clog2(DATAWIDTH + 1);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]           state;
    logic [CW-1:0]        cnt;
    logic [DATAWIDTH-1:0] shift, head, tail, word;
    logic [1:0]           occ;
    logic                 push, pop, frmErr;

    assign word   = {shift[DATAWIDTH-2:0], iSDAT};
    // a frame bit always restarts a word, so only non-frame bits can complete one
    assign push   = iSVLD & ~iSFRM & (state == SHIFT) & (cnt == CW'(DATAWIDTH - 1));
    assign frmErr = iSVLD & iSFRM & (state == SHIFT);
    assign oWINC  = occ != 2'd0;
    assign pop    = oWINC & ~iFULL;
    assign oWDAT  = oWINC ? head : '0;
    assign oBUSY  = (state == SHIFT) | oWINC;

    always_ff @(posedge iWCLK or posedge iWRST) begin
        if (iWRST) begin
            state <= IDLE;
            cnt   <= '0;
            shift <= '0;
        end else if (iSVLD) begin
            if (iSFRM) begin
                shift <= {{(DATAWIDTH-1){1'b0}}, iSDAT};
                cnt   <= CW'(1);
                state <= SHIFT;
            end else if (state == SHIFT) begin
                shift <= word;
                cnt   <= push ? '0 : cnt + CW'(1);
                state <= push ? IDLE : SHIFT;
            end
        end
    end

    always_ff @(posedge iWCLK or posedge iWRST) begin
        if (iWRST) begin
            head  <= '0;
            tail  <= '0;
            occ   <= '0;
            oWCNT <= '0;
            oOVF  <= 1'b0;
            oFERR <= 1'b0;
        end else begin
            oFERR <= frmErr | (oFERR & ~iCLR);
            oOVF  <= (push & ~pop & (occ == 2'd2)) | (oOVF & ~iCLR);
            if (pop)
                oWCNT <= oWCNT + CNTW'(1);
            // simultaneous push/pop keeps occupancy; the new word lands behind whatever remains
            if (push & pop) begin
                if (occ == 2'd1) begin
                    head <= word;
                end else begin
                    head <= tail;
                    tail <= word;
                end
            end else if (pop) begin
                head <= tail;
                occ  <= occ - 2'd1;
            end else if (push) begin
                if (occ == 2'd0) begin
                    head <= word;
                    occ  <= 2'd1;
                end else if (occ == 2'd1) begin
                    tail <= word;
                    occ  <= 2'd2;
                end
            end
        end
    end
endmodule

// File: tb/tb_fir_serial_wr_packer.sv
// tb_fir_serial_wr_packer: scoreboard bench for fir_serial_wr_packer
module tb_fir_serial_wr_packer;
    localparam int DW = 8;
    localparam int CW = 16;

    logic          iWCLK = 1'b0;
    logic          iWRST, iSDAT, iSVLD, iSFRM, iCLR, iFULL;
    logic [DW-1:0] oWDAT;
    logic          oWINC, oOVF, oFERR, oBUSY;
    logic [CW-1:0] oWCNT;

    int            nTests = 0;
    int            nFail  = 0;
    logic [DW-1:0] expQ[$];

    fir_serial_wr_packer #(.DATAWIDTH(DW), .CNTW(CW)) dut (
        .iWCLK(iWCLK), .iWRST(iWRST), .iSDAT(iSDAT), .iSVLD(iSVLD), .iSFRM(iSFRM),
        .iCLR(iCLR), .iFULL(iFULL), .oWDAT(oWDAT), .oWINC(oWINC), .oOVF(oOVF),
        .oFERR(oFERR), .oBUSY(oBUSY), .oWCNT(oWCNT)
    );

    always #5 iWCLK = ~iWCLK;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // inputs are stable mid-cycle, so a write seen here happens at the next rising edge
    always @(negedge iWCLK) begin
        if (!iWRST && oWINC && !iFULL) begin
            if (expQ.size() == 0)
                checkVal("unexpected_write", 32'(oWDAT), 32'hFFFF_FFFF);
            else
                checkVal("wdat", 32'(oWDAT), 32'(expQ.pop_front()));
        end
    end

    task automatic drive(input logic d, input logic f, input logic v);
        iSDAT = d;
        iSFRM = f;
        iSVLD = v;
        @(posedge iWCLK);
        #1;
    endtask

    task automatic sendWord(input logic [DW-1:0] w, input logic gap);
        for (int i = DW - 1; i >= 0; i--) begin
            drive(w[i], i == DW - 1, 1'b1);
            if (gap && i > 0)
                drive(1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        iWRST = 1'b1; iSDAT = 0; iSVLD = 0; iSFRM = 0; iCLR = 0; iFULL = 0;
        #2;
        checkVal("rst_winc", 32'(oWINC), 0);
        checkVal("rst_wdat", 32'(oWDAT), 0);
        checkVal("rst_busy", 32'(oBUSY), 0);
        checkVal("rst_wcnt", 32'(oWCNT), 0);
        checkVal("rst_flags", 32'({oOVF, oFERR}), 0);
        repeat (2) @(posedge iWCLK);
        #1 iWRST = 1'b0;

        // 0xA5 continuous; check the write appears exactly one cycle after the last bit
        expQ.push_back(8'hA5);
        for (int i = DW - 1; i >= 1; i--) begin
            drive(1'(8'hA5 >> i), i == DW - 1, 1'b1);
            if (i == DW - 1) checkVal("busy_shift", 32'(oBUSY), 1);
        end
        checkVal("a5_winc_early", 32'(oWINC), 0);
        drive(1'b1, 1'b0, 1'b1);
        checkVal("a5_winc", 32'(oWINC), 1);
        checkVal("a5_wdat", 32'(oWDAT), 32'hA5);
        drive(0, 0, 0);
        checkVal("a5_winc_done", 32'(oWINC), 0);
        checkVal("a5_wcnt", 32'(oWCNT), 1);
        checkVal("idle_busy", 32'(oBUSY), 0);

        // stray unframed bits, then 0x3C with iSVLD toggling
        drive(1, 0, 1); drive(0, 0, 1); drive(1, 0, 1);
        checkVal("stray_busy", 32'(oBUSY), 0);
        expQ.push_back(8'h3C);
        sendWord(8'h3C, 1'b1);
        checkVal("3c_wdat", 32'(oWDAT), 32'h3C);
        drive(0, 0, 0);
        checkVal("3c_wcnt", 32'(oWCNT), 2);

        // full FIFO: two words buffered, third dropped
        iFULL = 1'b1;
        expQ.push_back(8'h11);
        expQ.push_back(8'h22);
        sendWord(8'h11, 1'b0);
        sendWord(8'h22, 1'b0);
        checkVal("full_ovf_early", 32'(oOVF), 0);
        sendWord(8'h33, 1'b0);
        checkVal("full_ovf", 32'(oOVF), 1);
        drive(0, 0, 0); drive(0, 0, 0);
        checkVal("full_hold_winc", 32'(oWINC), 1);
        checkVal("full_hold_wdat", 32'(oWDAT), 32'h11);
        checkVal("full_hold_wcnt", 32'(oWCNT), 2);
        iFULL = 1'b0;
        drive(0, 0, 0);
        checkVal("drain1_wcnt", 32'(oWCNT), 3);
        checkVal("drain1_wdat", 32'(oWDAT), 32'h22);
        drive(0, 0, 0);
        checkVal("drain2_wcnt", 32'(oWCNT), 4);
        checkVal("drain2_winc", 32'(oWINC), 0);
        checkVal("ovf_sticky", 32'(oOVF), 1);

        // aborted partial word, then 0xF0
        drive(1, 1, 1); drive(0, 0, 1); drive(1, 0, 1); drive(1, 0, 1); drive(0, 0, 1);
        checkVal("ferr_early", 32'(oFERR), 0);
        expQ.push_back(8'hF0);
        sendWord(8'hF0, 1'b0);
        checkVal("ferr_set", 32'(oFERR), 1);
        checkVal("f0_wdat", 32'(oWDAT), 32'hF0);
        drive(0, 0, 0);
        checkVal("f0_wcnt", 32'(oWCNT), 5);

        // back-to-back words
        expQ.push_back(8'h01);
        expQ.push_back(8'h02);
        sendWord(8'h01, 1'b0);
        checkVal("b2b1_wdat", 32'(oWDAT), 32'h01);
        sendWord(8'h02, 1'b0);
        checkVal("b2b2_winc", 32'(oWINC), 1);
        checkVal("b2b2_wdat", 32'(oWDAT), 32'h02);
        drive(0, 0, 0);
        checkVal("b2b_wcnt", 32'(oWCNT), 7);
        iCLR = 1'b1;
        drive(0, 0, 0);
        iCLR = 1'b0;
        checkVal("clr_flags", 32'({oOVF, oFERR}), 0);

        // occupy buffer, start a word, clear coinciding with a framing error
        iFULL = 1'b1;
        sendWord(8'h55, 1'b0);
        drive(1, 1, 1); drive(0, 0, 1);
        iCLR = 1'b1;
        drive(1, 1, 1);
        iCLR = 1'b0;
        checkVal("clr_vs_set", 32'(oFERR), 1);
        checkVal("pre_rst_busy", 32'(oBUSY), 1);
        #3 iWRST = 1'b1;
        #1;
        checkVal("arst_outs", 32'({oWINC, oOVF, oFERR, oBUSY}), 0);
        checkVal("arst_wdat", 32'(oWDAT), 0);
        checkVal("arst_wcnt", 32'(oWCNT), 0);
        @(posedge iWCLK);
        #1 iWRST = 1'b0;
        iFULL = 1'b0;
        expQ.push_back(8'h7E);
        sendWord(8'h7E, 1'b0);
        checkVal("7e_wdat", 32'(oWDAT), 32'h7E);
        drive(0, 0, 0);
        checkVal("7e_wcnt", 32'(oWCNT), 1);
        drive(0, 0, 0);
        checkVal("queue_empty", 32'(expQ.size()), 0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
